// File: rtl/hdmi_tmds_enc.sv
// hdmi_tmds_enc: DVI 8b/10b TMDS encoder, RGB565 in, blue/green/red 10-bit words out, hsync/vsync on ch0.
// Latency: 3 register stages; inputs sampled at edge k show on tmds_ch* after edge k+2.
// Backpressure: none, one word per channel every vga_clk; `define TMDS_TEST_PAT_EN adds test_en colour bars.
module hdmi_tmds_enc #(
    parameter bit HSYNC_INV = 1'b0,
    parameter bit VSYNC_INV = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
`ifdef TMDS_TEST_PAT_EN
    input  logic        test_en,
`endif
    input  logic [15:0] rgb_data,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);

    // Channel index: 0 blue, 1 green, 2 red.
    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Transition-minimising stage: chain of XOR or XNOR, bit 8 flags which one was used.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d, input logic [3:0] n1);
        logic       use_xnor;
        logic [8:0] q;
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // DC-balancing stage: returns {next_cnt[4:0], word[9:0]}.
    function automatic logic [14:0] tmds_s3(input logic [8:0] qm, input logic [3:0] n1,
                                            input logic [3:0] n0, input logic signed [4:0] cnt,
                                            input logic den, input logic [1:0] c);
        logic signed [4:0] diff;
        logic signed [4:0] c_n;
        logic [9:0]        w;
        diff = $signed({1'b0, n1}) - $signed({1'b0, n0});
        if (!den) begin
            c_n = 5'sd0;
            case (c)
                2'b00:   w = 10'h354;
                2'b01:   w = 10'h0AB;
                2'b10:   w = 10'h154;
                default: w = 10'h2AB;
            endcase
        end else if ((cnt == 5'sd0) || (n1 == n0)) begin
            w   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            c_n = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            w   = {1'b1, qm[8], ~qm[7:0]};
            c_n = cnt - diff + (qm[8] ? 5'sd2 : 5'sd0);
        end else begin
            w   = {1'b0, qm[8], qm[7:0]};
            c_n = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        return {c_n, w};
    endfunction

    logic [2:0][7:0]  s1_d_nxt;
    logic [2:0][7:0]  s1_d;
    logic [2:0][3:0]  s1_n1;
    logic             s1_de;
    logic [1:0]       s1_c;
    logic [2:0][8:0]  s2_qm_nxt;
    logic [2:0][8:0]  s2_qm;
    logic [2:0][3:0]  s2_n1;
    logic [2:0][3:0]  s2_n0;
    logic             s2_de;
    logic [1:0]       s2_c;
    logic [2:0][14:0] s3_nxt;
    logic [2:0][4:0]  cnt;
    logic [2:0][9:0]  tmds_q;

`ifdef TMDS_TEST_PAT_EN
    logic [10:0] col_cnt;

    // Column position within the active line; bar index is col_cnt[9:7] (128 pixels per bar).
    always_ff @(posedge vga_clk) begin
        if (sys_rst || !de) col_cnt <= '0;
        else                col_cnt <= col_cnt + 11'd1;
    end
`endif

    // Expand RGB565 to 8 bits per channel by replicating MSBs; colour bars override when enabled.
    always_comb begin
        s1_d_nxt[0] = {rgb_data[4:0],   rgb_data[4:2]};
        s1_d_nxt[1] = {rgb_data[10:5],  rgb_data[10:9]};
        s1_d_nxt[2] = {rgb_data[15:11], rgb_data[15:13]};
`ifdef TMDS_TEST_PAT_EN
        // Bars white,yellow,cyan,green,magenta,red,blue,black: B=~idx[0], R=~idx[1], G=~idx[2].
        if (test_en) begin
            s1_d_nxt[0] = {8{~col_cnt[7]}};
            s1_d_nxt[1] = {8{~col_cnt[9]}};
            s1_d_nxt[2] = {8{~col_cnt[8]}};
        end
`endif
    end

    // Stage 1: register data, popcount and control bits.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s1_d  <= '0;
            s1_n1 <= '0;
            s1_de <= 1'b0;
            s1_c  <= 2'b00;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_d[i]  <= s1_d_nxt[i];
                s1_n1[i] <= popcnt8(s1_d_nxt[i]);
            end
            s1_de <= de;
            s1_c  <= {vsync ^ VSYNC_INV, hsync ^ HSYNC_INV};
        end
    end

    // Build q_m for every channel from stage-1 data.
    always_comb begin
        s2_qm_nxt = '0;
        for (int i = 0; i < 3; i++) s2_qm_nxt[i] = tmds_qm(s1_d[i], s1_n1[i]);
    end

    // Stage 2: register q_m with its ones/zeros counts.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s2_qm <= '0;
            s2_n1 <= '0;
            s2_n0 <= '0;
            s2_de <= 1'b0;
            s2_c  <= 2'b00;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s2_qm[i] <= s2_qm_nxt[i];
                s2_n1[i] <= popcnt8(s2_qm_nxt[i][7:0]);
                s2_n0[i] <= 4'd8 - popcnt8(s2_qm_nxt[i][7:0]);
            end
            s2_de <= s1_de;
            s2_c  <= s1_c;
        end
    end

    // Output word and next disparity per channel; only ch0 carries sync control.
    always_comb begin
        s3_nxt = '0;
        for (int i = 0; i < 3; i++)
            s3_nxt[i] = tmds_s3(s2_qm[i], s2_n1[i], s2_n0[i], cnt[i], s2_de,
                                (i == 0) ? s2_c : 2'b00);
    end

    // Stage 3: output words and running disparity counters.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt    <= '0;
            tmds_q <= {3{10'h354}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]    <= s3_nxt[i][14:10];
                tmds_q[i] <= s3_nxt[i][9:0];
            end
        end
    end

    assign tmds_ch0 = tmds_q[0];
    assign tmds_ch1 = tmds_q[1];
    assign tmds_ch2 = tmds_q[2];

endmodule
